// File: rtl/arb4_pkg.sv
// Shared arbiter types: state encoding, sizing constants and the one-hot to index helper.
// Combinational only; no latency or backpressure.
package arb4_pkg;

  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int TO_CYCLES = 16;
  localparam int TO_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // w3..w0 -> y1,y0; a zero vector maps to index 0
  function automatic logic [IDW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/rr_grant_enc.sv
// One-hot grant to 2-bit index encoder (y1 = g3|g2, y0 = g3|g1).
// Latency: combinational. Backpressure: none.
module rr_grant_enc
  import arb4_pkg::*;
(
  input  logic [NREQ-1:0] g,
  output logic [IDW-1:0]  y
);

  assign y[1] = g[3] | g[2];
  assign y[0] = g[3] | g[1];

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters; optional forced release under ARB_TIMEOUT_EN.
// Latency: req to gnt 1 clk; 2 dead cycles between grants. Backpressure: grant held until owner releases.
module rr_arbiter4
  import arb4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            timeout
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_d;
  logic [2*NREQ-1:0]   req2;
  logic [NREQ-1:0]     rot;
  logic [IDW-1:0]      win_id;
  logic                win_vld;
  logic                owner_rel;
  logic                force_rel;

  rr_grant_enc u_enc (
    .g (gnt),
    .y (gnt_id)
  );

  assign gnt_valid = |gnt;
  assign owner_rel = done[gnt_id] | ~req[gnt_id];

  // Rotate so bit 0 of rot is the requester at ptr; lowest set bit wins.
  assign req2 = {req, req};
  assign rot  = req2[ptr_q +: NREQ];

  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win_vld = 1'b1;
        win_id  = ptr_q + IDW'(j);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != ST_GRANT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // An owner release in the same cycle takes precedence and suppresses the pulse
  assign force_rel = (cnt_q == TO_W'(TO_CYCLES - 1)) & ~owner_rel;
`else
  assign force_rel = 1'b0;
`endif

  assign timeout = (state_q == ST_GRANT) & force_rel;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d   = NREQ'(1) << win_id;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_rel | force_rel) begin
          gnt_d   = '0;
          ptr_d   = gnt_id + 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_rr_arbiter4;
  import arb4_pkg::*;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [NREQ-1:0] want);
    chk({tag, "_gnt"}, 8'(gnt), 8'(want));
    chk({tag, "_id"},  8'(gnt_id), 8'(oh2idx(want)));
    chk({tag, "_vld"}, 8'(gnt_valid), 8'(|want));
  endtask

  // Pulse done for one cycle, then expect RELEASE, IDLE and the next grant.
  task automatic release_to(input logic [NREQ-1:0] d, input logic [NREQ-1:0] nxt, input string tag);
    done = d;
    @(negedge clk);
    done = '0;
    chk_gnt({tag, "_rel"}, '0);
    @(negedge clk);
    chk_gnt({tag, "_idle"}, '0);
    @(negedge clk);
    chk_gnt(tag, nxt);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 4'b0000;

    // reset with all requests pending
    repeat (2) @(negedge clk);
    chk_gnt("rst", 4'b0000);
    chk("rst_to", 8'(timeout), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_gnt("first", 4'b0001);

    // rotation 0,1,2,3,0 with done pulsed each grant
    for (int i = 1; i <= 4; i++) begin
      release_to(4'(1 << ((i - 1) % 4)), 4'(1 << (i % 4)), "order");
    end

    // owner 0 withdraws; only requester 2 left
    req = 4'b0100;
    @(negedge clk);
    chk_gnt("wd_rel", 4'b0000);
    @(negedge clk);
    chk_gnt("wd_idle", 4'b0000);
    @(negedge clk);
    chk_gnt("wd_g2", 4'b0100);

    // done on a non-granted line is ignored
    done = 4'b1000;
    @(negedge clk);
    done = 4'b0000;
    chk_gnt("ign1", 4'b0100);
    @(negedge clk);
    chk_gnt("ign2", 4'b0100);

    // real release leaves ptr=3; 0011 must wrap to requester 0
    done = 4'b0100;
    @(negedge clk);
    done = 4'b0000;
    req  = 4'b0011;
    chk_gnt("rel2", 4'b0000);
    @(negedge clk);
    chk_gnt("rel2_idle", 4'b0000);
    @(negedge clk);
    chk_gnt("wrap", 4'b0001);

    // hold grant 0 without done; this negedge is GRANT cycle 1
    repeat (TO_CYCLES - 2) @(negedge clk);
    chk_gnt("hold15", 4'b0001);
    chk("hold15_to", 8'(timeout), 8'd0);
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    chk_gnt("to16", 4'b0001);
    chk("to16_pulse", 8'(timeout), 8'd1);
    @(negedge clk);
    chk_gnt("to_rel", 4'b0000);
    chk("to_rel_to", 8'(timeout), 8'd0);
    @(negedge clk);
    chk_gnt("to_idle", 4'b0000);
    @(negedge clk);
    chk_gnt("to_next", 4'b0010);
`else
    chk_gnt("noto16", 4'b0001);
    chk("noto16_to", 8'(timeout), 8'd0);
    repeat (8) @(negedge clk);
    chk_gnt("noto24", 4'b0001);
    chk("noto24_to", 8'(timeout), 8'd0);
    release_to(4'b0001, 4'b0010, "noto_next");
`endif

    // async reset mid-grant (ptr is 1 here)
    #2;
    rst = 1'b1;
    #1;
    chk_gnt("arst", 4'b0000);
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_gnt("arst_ptr0", 4'b0001);

    rst = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    chk_gnt("rst2", 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk_gnt("rst2_g2", 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
